// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage: reusable elastic pipeline register between two core stages.
//
// Carries a DATA_W-bit packed payload with valid/ready handshakes on both sides.
// SKID=1 gives a two-entry stage (main + skid) whose in_ready depends only on
// registered state and hold. SKID=0 gives a single-entry stage whose in_ready
// passes out_ready through combinationally.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main entry)
//   hold              hazard stall: freezes the stage, blocks both handshakes
//   flush             empties the stage (overrides hold), drops same-cycle input
//   occupancy         number of valid entries (0..2)
//   flush_drops       saturating count of entries discarded by flush

module pipe_buf_stage #(
    parameter int unsigned        DATA_W = 64,
    parameter bit                 SKID   = 1'b1,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [7:0]        flush_drops
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [7:0]        drops_q, drops_d;
    logic [8:0]        drops_sum;
    logic              in_fire;
    logic              out_fire;

    // Occupancy is the entry count; the state encoding matches it.
    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_valid = (state_q != StEmpty) && !hold;
    assign out_data  = (state_q != StEmpty) ? main_q : BUBBLE;

    generate
        if (SKID) begin : g_skid_ready
            // Registered-only: no path from out_ready.
            assign in_ready = !hold && (state_q != StTwo);
        end else begin : g_pass_ready
            assign in_ready = !hold && ((state_q == StEmpty) || out_ready);
        end
    endgenerate

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign flush_drops = drops_q;

    assign drops_sum = {1'b0, drops_q} + {7'd0, occupancy};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drops_d = drops_q;
        if (flush) begin
            // Flush wins over hold and over any same-cycle input beat.
            state_d = StEmpty;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
            drops_d = drops_sum[8] ? 8'hFF : drops_sum[7:0];
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (out_fire && in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end else if (in_fire && SKID) begin
                        skid_d  = in_data;
                        state_d = StTwo;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            drops_q <= 8'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            drops_q <= drops_d;
        end
    end

endmodule

// File: tb/tb_pipe_buf_stage.sv
module tb_pipe_buf_stage;

    localparam int unsigned DW     = 16;
    localparam logic [15:0] BUBBLE = 16'hB0B0;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          hold;
    logic          flush;

    logic          in_ready_s, out_valid_s, in_ready_p, out_valid_p;
    logic [DW-1:0] out_data_s, out_data_p;
    logic [1:0]    occ_s, occ_p;
    logic [7:0]    drops_s, drops_p;

    pipe_buf_stage #(.DATA_W(DW), .SKID(1'b1), .BUBBLE(BUBBLE)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .in_data    (in_data),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .out_data   (out_data_s),
        .hold       (hold),
        .flush      (flush),
        .occupancy  (occ_s),
        .flush_drops(drops_s)
    );

    pipe_buf_stage #(.DATA_W(DW), .SKID(1'b0), .BUBBLE(BUBBLE)) u_pass (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_p),
        .in_data    (in_data),
        .out_valid  (out_valid_p),
        .out_ready  (out_ready),
        .out_data   (out_data_p),
        .hold       (hold),
        .flush      (flush),
        .occupancy  (occ_p),
        .flush_drops(drops_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: each stage is a FIFO of bounded capacity plus a drop counter.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_p[$];
    int            drops_ms = 0;
    int            drops_mp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic model_reset();
        q_s.delete();
        q_p.delete();
        drops_ms = 0;
        drops_mp = 0;
    endtask

    // Check all outputs of both stages against the reference for the current inputs.
    task automatic check_outputs(input string tag);
        int            ns, np;
        logic [DW-1:0] hs, hp;
        ns = q_s.size();
        np = q_p.size();
        hs = (ns != 0) ? q_s[0] : BUBBLE;
        hp = (np != 0) ? q_p[0] : BUBBLE;
        check({tag, ".s.out_valid"}, 32'(out_valid_s), 32'(ns != 0 && !hold));
        check({tag, ".s.out_data"},  32'(out_data_s),  32'(hs));
        check({tag, ".s.in_ready"},  32'(in_ready_s),  32'(!hold && ns < 2));
        check({tag, ".s.occupancy"}, 32'(occ_s),       32'(ns));
        check({tag, ".s.drops"},     32'(drops_s),     32'(drops_ms));
        check({tag, ".p.out_valid"}, 32'(out_valid_p), 32'(np != 0 && !hold));
        check({tag, ".p.out_data"},  32'(out_data_p),  32'(hp));
        check({tag, ".p.in_ready"},  32'(in_ready_p),  32'(!hold && (np == 0 || out_ready)));
        check({tag, ".p.occupancy"}, 32'(occ_p),       32'(np));
        check({tag, ".p.drops"},     32'(drops_p),     32'(drops_mp));
    endtask

    // One clock: drive, check mid-cycle, advance the reference, cross the edge.
    task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic hld, input logic fl);
        bit rs, vs, rp, vp;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
        #1;
        check_outputs(tag);
        rs = !hld && q_s.size() < 2;
        vs = !hld && q_s.size() != 0;
        rp = !hld && (q_p.size() == 0 || ordy);
        vp = !hld && q_p.size() != 0;
        if (fl) begin
            drops_ms = sat_add(drops_ms, q_s.size());
            drops_mp = sat_add(drops_mp, q_p.size());
            q_s.delete();
            q_p.delete();
        end else begin
            if (vs && ordy) void'(q_s.pop_front());
            if (iv && rs) q_s.push_back(id);
            if (vp && ordy) void'(q_p.pop_front());
            if (iv && rp) q_p.push_back(id);
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate: 1..8 back to back.
        for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
        cycle("stream_tail", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cycle("stream_idle", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill with A, B; C held off; then drain in order.
        cycle("bp", 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        cycle("bp", 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        cycle("bp_full", 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        check("bp.s.occ_two", 32'(occ_s), 32'd2);
        for (int i = 0; i < 4; i++) cycle("bp_drain", 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        cycle("bp_end", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cycle("bp_end", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Flush with two entries and a same-cycle beat that must be dropped.
        cycle("fl", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle("fl", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        cycle("fl_go", 1'b1, 16'h000D, 1'b0, 1'b0, 1'b1);
        cycle("fl_after", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("fl.s.drops_two", 32'(drops_s), 32'd2);

        // Hold: 0x5 frozen for three cycles, then released.
        cycle("hold_ld", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 16'h0077, 1'b1, 1'b1, 1'b0);
        cycle("hold_rel", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cycle("hold_ld2", 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        cycle("hold_fl", 1'b1, 16'h0007, 1'b1, 1'b1, 1'b1);
        cycle("hold_fl_after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Saturation of the drop counter.
        for (int i = 0; i < 130; i++) begin
            cycle("sat", 1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
            cycle("sat", 1'b1, 16'(16'h200 + i), 1'b0, 1'b0, 1'b0);
            cycle("sat", 1'b1, 16'h000D, 1'b0, 1'b0, 1'b1);
        end
        cycle("sat_end", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("sat.s.drops_255", 32'(drops_s), 32'd255);

        // Asynchronous reset mid-stream with the skid stage full.
        cycle("rst_fill", 1'b1, 16'h0031, 1'b0, 1'b0, 1'b0);
        cycle("rst_fill", 1'b1, 16'h0032, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle("rand", 1'($urandom_range(0, 9) < 7), 16'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
